div_seq_param: RTL

//  Parametrised sequential restoring divider, the successor to the team's fixed 16-bit divider.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_step.sv | 34 +++
 rtl/div_seq_param.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider:
//   state_e  - FSM state encoding (IDLE, LOAD, ITER, FIX)
//   clog2    - ceiling log2, used to size the iteration counter
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_e;

  // Smallest r with 2**r >= value (returns 1 for value <= 2 so a counter
  // is never zero bits wide).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring-division step, purely combinational.
//   rem_i [WIDTH:0]   partial remainder before the step
//   dvd_i [WIDTH-1:0] dividend shift register (quotient bits enter at LSB)
//   dsr_i [WIDTH-1:0] divisor magnitude
//   rem_o [WIDTH:0]   partial remainder after shift/trial/restore
//   dvd_o [WIDTH-1:0] dividend register shifted left, new quotient bit at LSB
// -----------------------------------------------------------------------------
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             q_bit;

  always_comb begin
    shifted = {rem_i[WIDTH-1:0], dvd_i[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, dsr_i};
    // A set top bit in rem_i means the shifted value exceeds WIDTH+1 bits and
    // is certainly >= divisor; otherwise the trial sign bit decides.
    q_bit   = rem_i[WIDTH] | ~trial[WIDTH+1];
    rem_o   = q_bit ? trial[WIDTH:0] : shifted;
    dvd_o   = {dvd_i[WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/div_seq_param.sv
// -----------------------------------------------------------------------------
// div_seq_param
// Parametrised sequential restoring divider (signed/unsigned), one quotient
// bit per cycle, fixed latency WIDTH+2 from accepted start to done.
//
// Handshake: start is accepted only on a rising clk edge where busy==0
// (state IDLE), which includes the cycle in which done is high. Operands and
// is_signed are sampled on that edge only. busy is high from the accepting
// edge until the edge that raises done; done is a one-cycle pulse and the
// results/flags are valid from that cycle and held afterwards.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start, is_signed       request and operand mode
//   dividend, divisor      operands [WIDTH-1:0]
//   busy, done             status
//   quotient, remainder    results [WIDTH-1:0]
//   div_by_zero, overflow  special-case flags
//   dbg_state              current FSM state
// -----------------------------------------------------------------------------
module div_seq_param
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow,
  output state_e           dbg_state
);

  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;           // raw operands sampled on accept
  logic             smode_q;            // signed mode for this operation
  logic             neg_q_q, neg_r_q;   // result sign corrections
  logic             dz_q, ovf_q;        // special cases detected in LOAD
  logic [WIDTH-1:0] dvd_q, dsr_q;
  logic [WIDTH:0]   rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             div_by_zero_q, overflow_q, done_q;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_dvd;
  logic             accept;

  assign accept = (state_q == IDLE) && start;

  // |MIN| wraps to MIN itself, which read unsigned is exactly 2^(WIDTH-1).
  always_comb begin
    a_mag = (smode_q && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag = (smode_q && b_q[WIDTH-1]) ? -b_q : b_q;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .dvd_o (step_dvd)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: state_d = ITER;
      ITER: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q           <= '0;
      b_q           <= '0;
      smode_q       <= 1'b0;
      neg_q_q       <= 1'b0;
      neg_r_q       <= 1'b0;
      dz_q          <= 1'b0;
      ovf_q         <= 1'b0;
      dvd_q         <= '0;
      dsr_q         <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q           <= dividend;
            b_q           <= divisor;
            smode_q       <= is_signed;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
          end
        end
        LOAD: begin
          dvd_q   <= a_mag;
          dsr_q   <= b_mag;
          rem_q   <= '0;
          cnt_q   <= '0;
          neg_q_q <= smode_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_r_q <= smode_q & a_q[WIDTH-1];
          dz_q    <= (b_q == '0);
          ovf_q   <= smode_q && (a_q == MIN_VAL) && (b_q == ALL_ONE);
        end
        ITER: begin
          rem_q <= step_rem;
          dvd_q <= step_dvd;
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          done_q <= 1'b1;
          if (dz_q) begin
            quotient_q    <= ALL_ONE;
            remainder_q   <= a_q;
            div_by_zero_q <= 1'b1;
          end else if (ovf_q) begin
            quotient_q  <= MIN_VAL;
            remainder_q <= '0;
            overflow_q  <= 1'b1;
          end else begin
            quotient_q  <= neg_q_q ? -dvd_q : dvd_q;
            remainder_q <= neg_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;
  assign dbg_state   = state_q;

endmodule
